// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: types and helpers shared by the mul_seq_radix slice.
//   state_t   : controller states (idle, run, negate-fix, done)
//   max_iter  : ceil(len/digit), the most RUN cycles one product can take
package mul_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int max_iter(input int len, input int digit);
    return (len + digit - 1) / digit;
  endfunction

endpackage

// File: rtl/mul_seq_radix_if.sv
// mul_seq_radix_if: operand/result handshake bundle of the radix multiplier.
//   START, SIGNED, A, B : request side (master drives)
//   BUSY, DONE, Y       : status and product (slave drives)
interface mul_seq_radix_if #(
  parameter int LEN = 16
);
  logic             START;
  logic             SIGNED;
  logic [LEN-1:0]   A;
  logic [LEN-1:0]   B;
  logic             BUSY;
  logic             DONE;
  logic [2*LEN-1:0] Y;

  modport master (output START, SIGNED, A, B, input BUSY, DONE, Y);
  modport slave  (input START, SIGNED, A, B, output BUSY, DONE, Y);
endinterface

// File: rtl/mul_seq_digit_mac.sv
// mul_seq_digit_mac: combinational multiply-accumulate of one multiplier digit.
//   acc   : running partial sum (2*LEN)
//   mcand : shifted multiplicand (2*LEN)
//   digit : current DIGIT-bit slice of the multiplier
//   sum   : acc + mcand*digit, modulo 2^(2*LEN)
module mul_seq_digit_mac #(
  parameter int LEN   = 16,
  parameter int DIGIT = 4
) (
  input  logic [2*LEN-1:0] acc,
  input  logic [2*LEN-1:0] mcand,
  input  logic [DIGIT-1:0] digit,
  output logic [2*LEN-1:0] sum
);

  logic [2*LEN-1:0] digit_ext_s;
  logic [2*LEN-1:0] prod_s;

  // Widen the digit so the product wraps at 2*LEN bits like the accumulator.
  always_comb begin
    digit_ext_s = {{(2*LEN-DIGIT){1'b0}}, digit};
    prod_s      = mcand * digit_ext_s;
    sum         = acc + prod_s;
  end

endmodule

// File: rtl/mul_seq_radix_chk.sv
// mul_seq_radix_chk: assertion-only observer of the multiplier controller.
//   clk, rst_n : clock and async active-low reset
//   start      : operand load request
//   state      : controller state
//   busy, done : status outputs
module mul_seq_radix_chk
  import mul_seq_pkg::*;
#(
  parameter int LEN   = 16,
  parameter int DIGIT = 4
) (
  input logic   clk,
  input logic   rst_n,
  input logic   start,
  input state_t state,
  input logic   busy,
  input logic   done
);

  localparam int MAX_ITER = max_iter(LEN, DIGIT);

  logic [31:0] run_cnt_r;

  // Count RUN cycles since the most recent operand load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_r <= 32'd0;
    end else if (start) begin
      run_cnt_r <= 32'd0;
    end else if (state == ST_RUN) begin
      run_cnt_r <= run_cnt_r + 32'd1;
    end else begin
      run_cnt_r <= run_cnt_r;
    end
  end

  a_run_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (state == ST_RUN && !start) |-> (run_cnt_r < 32'(MAX_ITER)));

  a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(busy && done));

endmodule

// File: rtl/mul_seq_radix.sv
// mul_seq_radix: sequential LEN x LEN -> 2*LEN multiplier, DIGIT bits per cycle.
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : slave side of mul_seq_radix_if (START/SIGNED/A/B in, BUSY/DONE/Y out)
// Signed operands are multiplied as magnitudes and the result negated in a
// single FIX cycle; RUN stops as soon as the remaining multiplier is zero.
module mul_seq_radix
  import mul_seq_pkg::*;
#(
  parameter int LEN   = 16,
  parameter int DIGIT = 4
) (
  input logic             CLK,
  input logic             RST_N,
  mul_seq_radix_if.slave  bus
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [2*LEN-1:0] acc_r;
  logic [2*LEN-1:0] mcand_r;
  logic [LEN-1:0]   mplier_r;
  logic             neg_r;

  logic [LEN-1:0]   a_mag_s;
  logic [LEN-1:0]   b_mag_s;
  logic             neg_load_s;
  logic [LEN-1:0]   mplier_shift_s;
  logic [2*LEN-1:0] mac_sum_s;

  // Operand magnitudes; the LEN-bit unsigned result makes |-2^(LEN-1)| exact.
  always_comb begin
    a_mag_s    = bus.A;
    b_mag_s    = bus.B;
    neg_load_s = bus.SIGNED & (bus.A[LEN-1] ^ bus.B[LEN-1]);
    if (bus.SIGNED && bus.A[LEN-1]) begin
      a_mag_s = ~bus.A + LEN'(1);
    end else begin
      a_mag_s = bus.A;
    end
    if (bus.SIGNED && bus.B[LEN-1]) begin
      b_mag_s = ~bus.B + LEN'(1);
    end else begin
      b_mag_s = bus.B;
    end
  end

  assign mplier_shift_s = mplier_r >> DIGIT;

  mul_seq_digit_mac #(
    .LEN   (LEN),
    .DIGIT (DIGIT)
  ) u_mac (
    .acc   (acc_r),
    .mcand (mcand_r),
    .digit (mplier_r[DIGIT-1:0]),
    .sum   (mac_sum_s)
  );

  // Next-state logic; START overrides every state so a request always restarts.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.START) begin
      state_nxt_s = ST_RUN;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_IDLE;
        ST_RUN: begin
          if (mplier_shift_s == {LEN{1'b0}}) begin
            state_nxt_s = neg_r ? ST_FIX : ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_FIX:  state_nxt_s = ST_DONE;
        ST_DONE: state_nxt_s = ST_DONE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath registers: load on START, accumulate in RUN, negate in FIX.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_r    <= {(2*LEN){1'b0}};
      mcand_r  <= {(2*LEN){1'b0}};
      mplier_r <= {LEN{1'b0}};
      neg_r    <= 1'b0;
    end else if (bus.START) begin
      acc_r    <= {(2*LEN){1'b0}};
      mcand_r  <= {{LEN{1'b0}}, a_mag_s};
      mplier_r <= b_mag_s;
      neg_r    <= neg_load_s;
    end else begin
      case (state_r)
        ST_RUN: begin
          acc_r    <= mac_sum_s;
          mcand_r  <= mcand_r << DIGIT;
          mplier_r <= mplier_shift_s;
        end
        ST_FIX: begin
          acc_r <= ~acc_r + {{(2*LEN-1){1'b0}}, 1'b1};
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  assign bus.BUSY = (state_r == ST_RUN) || (state_r == ST_FIX);
  assign bus.DONE = (state_r == ST_DONE);
  assign bus.Y    = acc_r;

  mul_seq_radix_chk #(
    .LEN   (LEN),
    .DIGIT (DIGIT)
  ) u_chk (
    .clk   (CLK),
    .rst_n (RST_N),
    .start (bus.START),
    .state (state_r),
    .busy  (bus.BUSY),
    .done  (bus.DONE)
  );

endmodule

// File: tb/tb_mul_seq_radix.sv
// tb_mul_seq_radix: drives four multipliers (DIGIT = 4, 1, 3, 16; LEN = 16)
// with identical operands and compares product and latency against an
// arithmetic reference, plus directed reset/restart sequences.
module tb_mul_seq_radix;

  localparam int LEN = 16;
  localparam int NI  = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sgn;
  logic [15:0] a;
  logic [15:0] b;

  logic [31:0] y_s    [NI];
  logic        busy_s [NI];
  logic        done_s [NI];

  int lat [NI];
  int n_checks = 0;
  int n_errors = 0;

  function automatic int dig(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : (i == 2) ? 3 : 16;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DG = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 3 : 16;
    mul_seq_radix_if #(.LEN(LEN)) bus ();
    assign bus.START  = start;
    assign bus.SIGNED = sgn;
    assign bus.A      = a;
    assign bus.B      = b;
    mul_seq_radix #(.LEN(LEN), .DIGIT(DG)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus)
    );
    assign y_s[g]    = bus.Y;
    assign busy_s[g] = bus.BUSY;
    assign done_s[g] = bus.DONE;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product: plain integer multiply of the interpreted operands.
  function automatic logic [31:0] exp_prod(input logic [15:0] ta, input logic [15:0] tbv,
                                           input logic ts);
    longint sa, sb, p;
    sa = ts ? longint'($signed(ta)) : longint'(ta);
    sb = ts ? longint'($signed(tbv)) : longint'(tbv);
    p  = sa * sb;
    return 32'(p);
  endfunction

  // Reference latency: digit groups needed to cover |B| (min 1), +1 if negating.
  function automatic int exp_lat(input logic [15:0] ta, input logic [15:0] tbv,
                                 input logic ts, input int d);
    longint mag;
    int     n;
    mag = (ts && tbv[15]) ? (longint'(65536) - longint'(tbv)) : longint'(tbv);
    n = 1;
    while ((mag >> (n * d)) != 0) n++;
    return n + ((ts && (ta[15] ^ tbv[15])) ? 1 : 0);
  endfunction

  task automatic chk(input string name, input int inst, input logic [63:0] act,
                     input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s inst%0d (digit %0d): got 0x%0h expected 0x%0h",
               name, inst, dig(inst), act, expv);
    end
  endtask

  // Present operands with START for one edge; busy must follow immediately.
  task automatic issue(input logic [15:0] ta, input logic [15:0] tbv, input logic ts);
    a = ta; b = tbv; sgn = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < NI; i++) chk("busy_after_start", i, 64'(busy_s[i]), 64'd1);
  endtask

  // Record, per instance, how many edges after the START edge DONE appears.
  task automatic wait_done();
    bit all_done;
    for (int i = 0; i < NI; i++) lat[i] = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      all_done = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (done_s[i] === 1'b1 && lat[i] == 0) lat[i] = cyc;
        if (lat[i] == 0) all_done = 1'b0;
      end
      if (all_done) break;
    end
    for (int i = 0; i < NI; i++) begin
      if (lat[i] == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL done_timeout inst%0d: no DONE within 40 cycles", i);
      end
    end
  endtask

  task automatic check_model(input logic [15:0] ta, input logic [15:0] tbv, input logic ts);
    wait_done();
    for (int i = 0; i < NI; i++) begin
      chk("product", i, 64'(y_s[i]), 64'(exp_prod(ta, tbv, ts)));
      if (lat[i] > 0) chk("latency", i, 64'(lat[i]), 64'(exp_lat(ta, tbv, ts, dig(i))));
      chk("busy_at_done", i, 64'(busy_s[i]), 64'd0);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [31:0] y;
    int          lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [15:0] ra, rb, mask;
    logic        rs;

    vecs[0] = '{a: 16'hFFFF, b: 16'hFFFF, s: 1'b0, y: 32'hFFFE0001, lat: 4};
    vecs[1] = '{a: 16'h1234, b: 16'h0000, s: 1'b0, y: 32'h00000000, lat: 1};
    vecs[2] = '{a: 16'h1234, b: 16'h0003, s: 1'b0, y: 32'h0000369C, lat: 1};
    vecs[3] = '{a: 16'hFFFD, b: 16'h0007, s: 1'b1, y: 32'hFFFFFFEB, lat: 2};
    vecs[4] = '{a: 16'h8000, b: 16'h8000, s: 1'b1, y: 32'h40000000, lat: 4};
    vecs[5] = '{a: 16'h8000, b: 16'h8000, s: 1'b0, y: 32'h40000000, lat: 4};
    vecs[6] = '{a: 16'h7FFF, b: 16'h8000, s: 1'b1, y: 32'hC0008000, lat: 5};
    vecs[7] = '{a: 16'h0001, b: 16'h0100, s: 1'b0, y: 32'h00000100, lat: 3};

    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; a = 16'h0000; b = 16'h0000;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("reset_y", i, 64'(y_s[i]), 64'd0);
      chk("reset_busy", i, 64'(busy_s[i]), 64'd0);
      chk("reset_done", i, 64'(done_s[i]), 64'd0);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 0, 64'(busy_s[0]), 64'd0);
    chk("idle_done", 0, 64'(done_s[0]), 64'd0);

    // Directed table, all instances also checked against the model.
    for (int v = 0; v < 8; v++) begin
      issue(vecs[v].a, vecs[v].b, vecs[v].s);
      check_model(vecs[v].a, vecs[v].b, vecs[v].s);
      chk("tbl_y", 0, 64'(y_s[0]), 64'(vecs[v].y));
      chk("tbl_lat", 0, 64'(lat[0]), 64'(vecs[v].lat));
    end

    // Reset two cycles into a run clears outputs before the next edge.
    issue(16'hFFFF, 16'hFFFF, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_before_reset", 0, 64'(busy_s[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("midrun_reset_y", i, 64'(y_s[i]), 64'd0);
      chk("midrun_reset_busy", i, 64'(busy_s[i]), 64'd0);
      chk("midrun_reset_done", i, 64'(done_s[i]), 64'd0);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_done", 0, 64'(done_s[0]), 64'd0);
    chk("post_reset_busy", 0, 64'(busy_s[0]), 64'd0);

    // Restart during the second RUN cycle: only the new product completes.
    issue(16'h00FF, 16'h0FFF, 1'b0);
    @(posedge clk); #1;
    chk("restart_no_done", 0, 64'(done_s[0]), 64'd0);
    issue(16'h0005, 16'h0006, 1'b0);
    chk("restart_no_done2", 0, 64'(done_s[0]), 64'd0);
    check_model(16'h0005, 16'h0006, 1'b0);
    chk("restart_y", 0, 64'(y_s[0]), 64'h1E);

    // START held for several edges keeps reloading; last operands win.
    a = 16'h0007; b = 16'h0007; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'hFFFF; sgn = 1'b1;
    @(posedge clk); #1;
    chk("held_busy", 0, 64'(busy_s[0]), 64'd1);
    issue(16'h0010, 16'h0020, 1'b0);
    check_model(16'h0010, 16'h0020, 1'b0);

    // START on the edge where RUN would finish: old result never flagged.
    issue(16'h1234, 16'h0003, 1'b0);
    issue(16'h0002, 16'h0100, 1'b0);
    chk("collide_no_done", 0, 64'(done_s[0]), 64'd0);
    check_model(16'h0002, 16'h0100, 1'b0);

    // DONE and Y hold with no further START.
    issue(16'hFFFE, 16'h0123, 1'b1);
    check_model(16'hFFFE, 16'h0123, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_done", 0, 64'(done_s[0]), 64'd1);
    chk("hold_y", 0, 64'(y_s[0]), 64'(exp_prod(16'hFFFE, 16'h0123, 1'b1)));

    // Random operands with varied multiplier magnitudes.
    for (int r = 0; r < 40; r++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0: mask = 16'h000F;
        1: mask = 16'h00FF;
        2: mask = 16'h0FFF;
        default: mask = 16'hFFFF;
      endcase
      rb = 16'($urandom) & mask;
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      rs = 1'($urandom_range(0, 1));
      if (rs) begin
        if (ra == 16'h0000) ra = 16'h0001;
        if (rb == 16'h0000) rb = 16'h0001;
      end
      issue(ra, rb, rs);
      check_model(ra, rb, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul_seq_radix.md
# mul_seq_radix

Parametrised sequential multiplier producing a full 2·LEN-bit product in DIGIT-bit radix steps, with selectable signed/unsigned mode, early termination on exhausted multiplier digits, and a START/BUSY/DONE handshake. It is the drop-in arithmetic unit for LEN-bit datapaths where a single-cycle multiplier costs too much area. Its ports are driven directly by the surrounding control logic.

## Interface
- LEN, 16: operand width in bits; must be ≥ 2.
- DIGIT, 4: multiplier bits consumed per cycle; 1 ≤ DIGIT ≤ LEN; need not divide LEN.
- CLK  input  1  clock; all state changes on the rising edge.
- RST_N  input  1  reset; asynchronous, active-low.
- START  input  1  load operands and begin; sampled every cycle.
- SIGNED  input  1  sampled with START: 1 = two's-complement operands, 0 = unsigned.
- A  input  LEN  multiplicand, sampled with START.
- B  input  LEN  multiplier, sampled with START.
- BUSY  output  1  high in RUN or FIX.
- DONE  output  1  high in DONE state; product valid.
- Y  output  2·LEN  accumulator; holds the product while DONE=1.

## Operation
- States: IDLE, RUN, FIX, DONE.
- Registers:
  - acc (2·LEN bits)
  - mcand (2·LEN bits)
  - mplier (LEN bits)
  - neg (1 bit)
  - state
- START=1 in any state, including RUN or FIX, aborts any operation in flight.
  - Loads mcand = zero-extended |A| and mplier = |B|.
  - Clears acc.
  - Sets neg = SIGNED & (A[LEN-1] ^ B[LEN-1]).
  - Enters RUN.
- Unsigned mode: |x| = x.
- Signed mode: |x| = two's-complement magnitude as an unsigned LEN-bit value. |−2^(LEN−1)| = 2^(LEN−1) and is exact.
- RUN, every cycle:
  - acc += mcand · mplier[DIGIT−1:0]
  - mcand <<= DIGIT
  - mplier >>= DIGIT
  - If the shifted mplier is 0, leave RUN: go to FIX if neg, otherwise to DONE.
- FIX: acc ← −acc (mod 2^(2·LEN)), then DONE.
- DONE: Y, DONE=1 held indefinitely until the next START.
- IDLE: reached only from reset. DONE=0, BUSY=0.
- Width rules: all arithmetic is mod 2^(2·LEN). The final magnitude product is < 2^(2·LEN), so no overflow is possible.
- Y during RUN/FIX shows partial sums and is not valid.

## Timing
- Reset values: state=IDLE, acc=0 (so Y=0), DONE=0, BUSY=0, mcand=0, mplier=0, neg=0.
- Reset takes effect immediately on RST_N low, including mid-operation; the first START after release behaves normally.
- Define k = max(1, number of DIGIT-wide groups up to and including the highest nonzero digit of |B|). Then 1 ≤ k ≤ ceil(LEN/DIGIT).
- If START is sampled at edge T:
  - BUSY rises after edge T.
  - RUN occupies edges T+1 … T+k.
  - FIX, if taken, occupies edge T+k+1.
  - DONE rises after edge T+k (unsigned or non-negative result) or after edge T+k+1 (negative result), and BUSY falls in the same cycle.
- B = 0: k = 1, so one RUN cycle, and the result is 0 with no FIX.
- START held high keeps reloading; computation proceeds from the first cycle START is low.
- START in the same cycle the state would reach DONE: START wins, and DONE does not assert for the old operation.

## Structure
- Package mul_seq_pkg holds:
  - the state enum (IDLE, RUN, FIX, DONE)
  - a function for the ceil(LEN/DIGIT) maximum iteration count, used by assertions.
- Sub-module mul_seq_digit_mac: combinational, computes acc + mcand · digit over 2·LEN bits. Parameters LEN and DIGIT. Instantiated once.
- Top-level FSM and registers are in mul_seq_radix.

## Test plan
All scenarios use LEN=16, DIGIT=4 unless noted.
- Reset mid-RUN: assert RST_N=0 two cycles after START → Y=0, DONE=0, BUSY=0 immediately, before the next clock edge.
- Unsigned full-width: A=0xFFFF, B=0xFFFF → Y=0xFFFE0001; DONE rises after exactly 4 RUN cycles. B=0 → Y=0 after 1 cycle.
- Early termination: unsigned A=0x1234, B=0x0003 → Y=0x0000369C with DONE after 1 RUN cycle.
- Signed negative: A=0xFFFD (−3), B=0x0007 → Y=0xFFFFFFEB; 1 RUN + 1 FIX, DONE after 2 cycles. Signed A=0x8000, B=0x8000 → Y=0x40000000 after 4 RUN cycles, no FIX.
- Restart: START with 0x00FF×0x0FFF, then START again during the 2nd RUN cycle with 5×6 → Y=0x0000001E; the first result is never flagged DONE.
- Parameter sweep: DIGIT ∈ {1, 3, 16} with random signed and unsigned operands. Each result must match the reference product, and the cycle count must equal the k formula (+1 when a FIX is taken).
